// File: rtl/id_pool_nwmr.sv
// Free-list ID pool with N_WR release lanes and N_RD allocate lanes, FIFO hand-out order.
// An allocated-ID bitmap rejects releases of IDs that are out of range, not held, or duplicated in one cycle.
module id_pool_nwmr_rel_lane #(
    parameter int DEPTH = 16,
    parameter int ID_W  = 4,
    parameter int CNT_W = 5
) (
    input  logic             srdy,
    input  logic [CNT_W-1:0] rank,
    input  logic [CNT_W-1:0] free_slots,
    input  logic [ID_W-1:0]  id,
    input  logic [DEPTH-1:0] alloc,
    output logic             drdy,
    output logic             known
);
    // rank counts requesting lanes up to and including this one, so holes compact
    assign drdy  = srdy && (rank <= free_slots);
    assign known = (int'(id) < DEPTH) ? alloc[id] : 1'b0;
endmodule

module id_pool_nwmr #(
    parameter int DEPTH = 16,
    parameter int ID_W  = $clog2(DEPTH),
    parameter int N_WR  = 2,
    parameter int N_RD  = 2,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N_WR-1:0]      c_srdy,
    output logic [N_WR-1:0]      c_drdy,
    input  logic [N_WR*ID_W-1:0] c_data,
    output logic [N_RD-1:0]      p_srdy,
    input  logic [N_RD-1:0]      p_drdy,
    output logic [N_RD*ID_W-1:0] p_data,
    output logic [CNT_W-1:0]     usage,
    output logic                 err_dbl_rel
);
    localparam int AW = ID_W + 1;

    function automatic logic [ID_W-1:0] wrap(input logic [AW-1:0] a);
        return (a >= AW'(DEPTH)) ? ID_W'(a - AW'(DEPTH)) : a[ID_W-1:0];
    endfunction

    logic [DEPTH-1:0][ID_W-1:0] slots;
    logic [ID_W-1:0]            rd_ptr, wr_ptr;
    logic [DEPTH-1:0]           alloc, alloc_n;

    logic [N_RD-1:0][ID_W-1:0]  rd_idx, pdat;
    logic [N_RD-1:0]            pop;
    logic [CNT_W-1:0]           pop_cnt, push_cnt, free_slots;

    logic [N_WR-1:0][ID_W-1:0]  rel_id, wr_idx;
    logic [N_WR-1:0][CNT_W-1:0] rank;
    logic [N_WR-1:0]            known, valid;

    assign p_data     = pdat;
    assign rel_id     = c_data;
    assign free_slots = CNT_W'(DEPTH) - usage;

    genvar k;
    generate
        for (k = 0; k < N_RD; k++) begin : g_rd
            assign rd_idx[k] = wrap({1'b0, rd_ptr} + AW'(k));
            assign p_srdy[k] = usage > CNT_W'(k);
            assign pdat[k]   = slots[rd_idx[k]];
            assign pop[k]    = p_srdy[k] & (&p_drdy[k:0]);
        end
        for (k = 0; k < N_WR; k++) begin : g_wr
            id_pool_nwmr_rel_lane #(.DEPTH(DEPTH), .ID_W(ID_W), .CNT_W(CNT_W)) u_lane (
                .srdy       (c_srdy[k]),
                .rank       (rank[k]),
                .free_slots (free_slots),
                .id         (rel_id[k]),
                .alloc      (alloc),
                .drdy       (c_drdy[k]),
                .known      (known[k])
            );
        end
    endgenerate

    always_comb begin
        pop_cnt = '0;
        for (int i = 0; i < N_RD; i++) pop_cnt += CNT_W'(pop[i]);
    end

    always_comb begin
        logic [CNT_W-1:0] r;
        r = '0;
        for (int i = 0; i < N_WR; i++) begin
            r += CNT_W'(c_srdy[i]);
            rank[i] = r;
        end
    end

    // Duplicate check is against any lower accepted lane, valid or not
    always_comb begin
        logic dup;
        push_cnt = '0;
        for (int i = 0; i < N_WR; i++) begin
            dup = 1'b0;
            for (int j = 0; j < i; j++)
                if (c_drdy[j] && rel_id[j] == rel_id[i]) dup = 1'b1;
            valid[i]  = c_drdy[i] & known[i] & ~dup;
            wr_idx[i] = wrap({1'b0, wr_ptr} + AW'(push_cnt));
            push_cnt += CNT_W'(valid[i]);
        end
    end

    always_comb begin
        alloc_n = alloc;
        for (int i = 0; i < N_RD; i++)
            if (pop[i]) alloc_n[pdat[i]] = 1'b1;
        for (int i = 0; i < N_WR; i++)
            if (valid[i]) alloc_n[rel_id[i]] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) slots[i] <= ID_W'(i);
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            usage       <= CNT_W'(DEPTH);
            alloc       <= '0;
            err_dbl_rel <= 1'b0;
        end else begin
            for (int i = 0; i < N_WR; i++)
                if (valid[i]) slots[wr_idx[i]] <= rel_id[i];
            rd_ptr      <= wrap({1'b0, rd_ptr} + AW'(pop_cnt));
            wr_ptr      <= wrap({1'b0, wr_ptr} + AW'(push_cnt));
            usage       <= usage + push_cnt - pop_cnt;
            alloc       <= alloc_n;
            err_dbl_rel <= err_dbl_rel | (|(c_drdy & ~valid));
        end
    end

    a_usage_max: assert property (@(posedge clk) disable iff (!rst_n) usage <= CNT_W'(DEPTH));
    a_usage_min: assert property (@(posedge clk) disable iff (!rst_n)
                                  (AW'(usage) + AW'(push_cnt)) >= AW'(pop_cnt));
endmodule
